// File: rtl/usb4_lt_pkg.sv
// Shared USB4 lane-training definitions: SLOS sequencer state encoding and
// checker polarity selects.
package usb4_lt_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_SLOS1 = 3'd1,
        REARM      = 3'd2,
        WAIT_SLOS2 = 3'd3,
        DONE       = 3'd4,
        FAIL       = 3'd5
    } slos_state_e;

    localparam int   SLOS_PRBS_PERIOD = 2047;
    localparam logic SLOS_SEL_SLOS1   = 1'b0;
    localparam logic SLOS_SEL_SLOS2   = 1'b1;

endpackage

// File: rtl/slos_rx_seq.sv
// Sequences the PRBS11 checker through SLOS1 then SLOS2 streak detection.
// Latency: all outputs registered, response visible after the sampling edge.
// Backpressure: none; slos_rec pulses are consumed every cycle (ignored in REARM).
module slos_rx_seq
    import usb4_lt_pkg::*;
#(
    parameter int REQ_SLOS1   = 2,
    parameter int REQ_SLOS2   = 2,
    parameter int SLOS_WIN    = 4100,
    parameter int TIMEOUT_CYC = 16384,
    parameter int TMR_W       = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    input  logic       slos_rec,
    output logic       chk_enable,
    output logic       chk_slos_sel,
    output logic       slos1_done,
    output logic       done,
    output logic       timeout_err,
    output logic [2:0] state,
    output logic [3:0] slos_cnt
);

    localparam logic [3:0]       L_REQ1_LAST = 4'(REQ_SLOS1 - 1);
    localparam logic [3:0]       L_REQ2_LAST = 4'(REQ_SLOS2 - 1);
    localparam logic [TMR_W-1:0] L_TO_LAST   = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [TMR_W-1:0] L_WIN       = TMR_W'(SLOS_WIN);
    localparam logic [TMR_W-1:0] L_WIN_M1    = TMR_W'(SLOS_WIN - 1);

    slos_state_e      r_state;
    logic             r_chk_enable;
    logic             r_chk_slos_sel;
    logic             r_slos1_done;
    logic             r_done;
    logic             r_timeout_err;
    logic [3:0]       r_slos_cnt;
    logic [TMR_W-1:0] r_gap;
    logic [TMR_W-1:0] r_phase;

    logic [3:0]       w_req_last;
    logic             w_complete;
    logic             w_phase_end;

    assign w_req_last  = (r_state == WAIT_SLOS1) ? L_REQ1_LAST : L_REQ2_LAST;
    assign w_complete  = slos_rec && (r_slos_cnt == w_req_last);
    assign w_phase_end = (r_phase == L_TO_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= IDLE;
            r_chk_enable   <= 1'b0;
            r_chk_slos_sel <= SLOS_SEL_SLOS1;
            r_slos1_done   <= 1'b0;
            r_done         <= 1'b0;
            r_timeout_err  <= 1'b0;
            r_slos_cnt     <= '0;
            r_gap          <= '0;
            r_phase        <= '0;
        end else begin
            r_slos1_done <= 1'b0;
            if (abort) begin
                r_state        <= IDLE;
                r_chk_enable   <= 1'b0;
                r_chk_slos_sel <= SLOS_SEL_SLOS1;
                r_done         <= 1'b0;
                r_timeout_err  <= 1'b0;
                r_slos_cnt     <= '0;
                r_gap          <= '0;
                r_phase        <= '0;
            end else begin
                case (r_state)
                    IDLE, DONE, FAIL: begin
                        if (start) begin
                            r_state        <= WAIT_SLOS1;
                            r_chk_enable   <= 1'b1;
                            r_chk_slos_sel <= SLOS_SEL_SLOS1;
                            r_done         <= 1'b0;
                            r_timeout_err  <= 1'b0;
                            r_slos_cnt     <= '0;
                            r_gap          <= '0;
                            r_phase        <= '0;
                        end
                    end
                    WAIT_SLOS1, WAIT_SLOS2: begin
                        // completion is checked before timeout so it wins a tie
                        if (w_complete) begin
                            r_chk_enable <= 1'b0;
                            r_slos_cnt   <= '0;
                            if (r_state == WAIT_SLOS1) begin
                                r_state        <= REARM;
                                r_slos1_done   <= 1'b1;
                                r_chk_slos_sel <= SLOS_SEL_SLOS2;
                            end else begin
                                r_state <= DONE;
                                r_done  <= 1'b1;
                            end
                        end else if (w_phase_end) begin
                            r_state       <= FAIL;
                            r_timeout_err <= 1'b1;
                            r_chk_enable  <= 1'b0;
                            r_slos_cnt    <= '0;
                        end else begin
                            r_phase <= r_phase + 1'b1;
                            if (slos_rec) begin
                                r_slos_cnt <= r_slos_cnt + 1'b1;
                                r_gap      <= '0;
                            end else if ((r_gap == L_WIN_M1) && (r_slos_cnt != 4'd0)) begin
                                r_slos_cnt <= '0;
                                r_gap      <= '0;
                            end else if (r_gap != L_WIN) begin
                                r_gap <= r_gap + 1'b1;
                            end
                        end
                    end
                    REARM: begin
                        r_state      <= WAIT_SLOS2;
                        r_chk_enable <= 1'b1;
                        r_gap        <= '0;
                        r_phase      <= '0;
                    end
                    default: begin
                        r_state        <= IDLE;
                        r_chk_enable   <= 1'b0;
                        r_chk_slos_sel <= SLOS_SEL_SLOS1;
                        r_slos_cnt     <= '0;
                        r_gap          <= '0;
                        r_phase        <= '0;
                    end
                endcase
            end
        end
    end

    assign chk_enable   = r_chk_enable;
    assign chk_slos_sel = r_chk_slos_sel;
    assign slos1_done   = r_slos1_done;
    assign done         = r_done;
    assign timeout_err  = r_timeout_err;
    assign state        = r_state;
    assign slos_cnt     = r_slos_cnt;

endmodule

// File: tb/tb_slos_rx_seq.sv
// Directed bench for slos_rx_seq with small timers (WIN=16, TIMEOUT=64).
module tb_slos_rx_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       abort;
    logic       slos_rec;
    logic       chk_enable;
    logic       chk_slos_sel;
    logic       slos1_done;
    logic       done;
    logic       timeout_err;
    logic [2:0] state;
    logic [3:0] slos_cnt;

    int total = 0;
    int bad   = 0;

    slos_rx_seq #(
        .REQ_SLOS1  (2),
        .REQ_SLOS2  (2),
        .SLOS_WIN   (16),
        .TIMEOUT_CYC(64),
        .TMR_W      (7)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .slos_rec    (slos_rec),
        .chk_enable  (chk_enable),
        .chk_slos_sel(chk_slos_sel),
        .slos1_done  (slos1_done),
        .done        (done),
        .timeout_err (timeout_err),
        .state       (state),
        .slos_cnt    (slos_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        start    = 1'b0;
        abort    = 1'b0;
        slos_rec = 1'b0;
        repeat (n) tick();
    endtask

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_s(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_c(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk_s({tag, ".state"}, state, 3'd0);
        chk_b({tag, ".en"}, chk_enable, 1'b0);
        chk_b({tag, ".sel"}, chk_slos_sel, 1'b0);
        chk_b({tag, ".s1done"}, slos1_done, 1'b0);
        chk_b({tag, ".done"}, done, 1'b0);
        chk_b({tag, ".tmo"}, timeout_err, 1'b0);
        chk_c({tag, ".cnt"}, slos_cnt, 4'd0);
    endtask

    initial begin
        reset    = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        slos_rec = 1'b0;

        // 1. reset then 10 idle cycles
        repeat (3) tick();
        chk_zero("rst");
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk_zero("idle");
        end

        // 2. nominal sequence
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_s("nom.st1", state, 3'd1);
        chk_b("nom.en1", chk_enable, 1'b1);
        chk_b("nom.sel1", chk_slos_sel, 1'b0);
        idle(4);
        slos_rec = 1'b1;
        tick();
        chk_c("nom.cnt1", slos_cnt, 4'd1);
        chk_s("nom.still1", state, 3'd1);
        idle(4);
        slos_rec = 1'b1;
        tick();
        chk_s("nom.rearm", state, 3'd2);
        chk_b("nom.s1done", slos1_done, 1'b1);
        chk_b("nom.en_rearm", chk_enable, 1'b0);
        chk_b("nom.sel_rearm", chk_slos_sel, 1'b1);
        chk_c("nom.cnt_rearm", slos_cnt, 4'd0);
        slos_rec = 1'b1;
        tick();
        slos_rec = 1'b0;
        chk_s("nom.st3", state, 3'd3);
        chk_b("nom.s1done_off", slos1_done, 1'b0);
        chk_b("nom.en2", chk_enable, 1'b1);
        chk_b("nom.sel2", chk_slos_sel, 1'b1);
        chk_c("nom.rearm_ignored", slos_cnt, 4'd0);
        idle(3);
        slos_rec = 1'b1;
        tick();
        chk_c("nom.cnt2", slos_cnt, 4'd1);
        idle(4);
        slos_rec = 1'b1;
        tick();
        chk_s("nom.done_st", state, 3'd4);
        chk_b("nom.done", done, 1'b1);
        chk_b("nom.en_done", chk_enable, 1'b0);
        chk_c("nom.cnt_done", slos_cnt, 4'd0);
        idle(1);
        chk_b("nom.done_held", done, 1'b1);
        chk_s("nom.done_st_held", state, 3'd4);

        // 3. broken streak, restart from DONE
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_s("brk.st1", state, 3'd1);
        chk_b("brk.done_clr", done, 1'b0);
        chk_b("brk.sel", chk_slos_sel, 1'b0);
        chk_b("brk.en", chk_enable, 1'b1);
        idle(4);
        slos_rec = 1'b1;
        tick();
        chk_c("brk.cnt1", slos_cnt, 4'd1);
        slos_rec = 1'b0;
        start    = 1'b1;
        tick();
        chk_s("brk.start_ign", state, 3'd1);
        idle(14);
        chk_c("brk.cnt_15gap", slos_cnt, 4'd1);
        idle(1);
        chk_c("brk.cnt_16gap", slos_cnt, 4'd0);
        idle(3);
        slos_rec = 1'b1;
        tick();
        chk_c("brk.cnt_re1", slos_cnt, 4'd1);
        chk_s("brk.no_exit", state, 3'd1);
        idle(4);
        slos_rec = 1'b1;
        tick();
        slos_rec = 1'b0;
        chk_s("brk.rearm", state, 3'd2);
        tick();
        chk_s("brk.st3", state, 3'd3);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk_zero("brk.abort");

        // 4. timeout
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_s("tmo.st1", state, 3'd1);
        idle(63);
        chk_s("tmo.before", state, 3'd1);
        chk_b("tmo.before_err", timeout_err, 1'b0);
        idle(1);
        chk_s("tmo.fail", state, 3'd5);
        chk_b("tmo.err", timeout_err, 1'b1);
        chk_b("tmo.en", chk_enable, 1'b0);
        idle(1);
        chk_b("tmo.err_held", timeout_err, 1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_s("tmo.restart", state, 3'd1);
        chk_b("tmo.err_clr", timeout_err, 1'b0);
        chk_b("tmo.en_restart", chk_enable, 1'b1);

        // 5. completion on the timeout cycle (phase timer 63)
        idle(50);
        slos_rec = 1'b1;
        tick();
        chk_c("tie.cnt1", slos_cnt, 4'd1);
        idle(12);
        chk_s("tie.pre", state, 3'd1);
        chk_c("tie.cnt_pre", slos_cnt, 4'd1);
        slos_rec = 1'b1;
        tick();
        slos_rec = 1'b0;
        chk_s("tie.rearm", state, 3'd2);
        chk_b("tie.no_err", timeout_err, 1'b0);
        chk_b("tie.s1done", slos1_done, 1'b1);
        tick();
        chk_s("tie.st3", state, 3'd3);

        // 6a. abort together with slos_rec in WAIT_SLOS2
        slos_rec = 1'b1;
        tick();
        chk_c("abt.cnt1", slos_cnt, 4'd1);
        abort    = 1'b1;
        slos_rec = 1'b1;
        tick();
        abort    = 1'b0;
        slos_rec = 1'b0;
        chk_zero("abt");

        // 6b. async reset mid WAIT_SLOS1
        start = 1'b1;
        tick();
        start    = 1'b0;
        slos_rec = 1'b1;
        tick();
        slos_rec = 1'b0;
        chk_c("ar.cnt1", slos_cnt, 4'd1);
        #2;
        reset = 1'b0;
        #1;
        chk_zero("ar.immediate");
        tick();
        reset = 1'b1;
        tick();
        chk_zero("ar.release");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
